// File: rtl/pool2x2_window_feeder.sv
// ============================================================================
// pool2x2_window_feeder
// Streams a row-major map into 2x2 windows, drives the pooler, emits results.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pool2x2_window_feeder #(
  parameter int W = 28,
  parameter int H = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic                   pool_start,
  output logic [1:0][1:0][15:0]  pool_win,
  input  logic                   pool_finish,
  input  logic [15:0]            pool_pixel,
  output logic [15:0]            out_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_done
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_ISSUE  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic                    rdy_q;
  logic [15:0]             rowbuf_q [W];
  logic [15:0]             bl_hold_q;
  logic [1:0][1:0][15:0]   win_q;
  logic [15:0]             out_pix_q;
  logic                    last_q;
  logic                    fd_q;

  logic                    w_hs;
  logic                    w_col_last;
  logic                    w_row_last;
  logic                    w_row_odd;
  logic                    w_col_odd;
  logic                    w_blk_done;
  logic [CW-1:0]           w_left_addr;

  assign w_hs        = pix_valid & pix_ready;
  assign w_col_last  = (col_q == CW'(W - 1));
  assign w_row_last  = (row_q == RW'(H - 1));
  assign w_row_odd   = row_q[0];
  assign w_col_odd   = col_q[0];
  assign w_blk_done  = w_hs & w_row_odd & w_col_odd;
  assign w_left_addr = col_q - CW'(1);

  // rdy_q keeps the input closed until the first edge after reset release.
  assign pix_ready  = rdy_q && (state_q == S_FILL);
  assign pool_start = (state_q == S_ISSUE);
  assign out_valid  = (state_q == S_OUTPUT);
  assign pool_win   = win_q;
  assign out_pixel  = out_pix_q;
  assign frame_done = fd_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;

    if (w_hs) begin
      if (w_col_last) begin
        col_d = '0;
        row_d = w_row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      S_FILL:   if (w_blk_done)  state_d = S_ISSUE;
      S_ISSUE:  if (pool_finish) state_d = S_OUTPUT;
      S_OUTPUT: if (out_ready)   state_d = S_FILL;
      default:                   state_d = S_FILL;
    endcase
  end

  // Top row of the current block pair; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_hs && !w_row_odd) begin
      rowbuf_q[col_q] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FILL;
      col_q     <= '0;
      row_q     <= '0;
      rdy_q     <= 1'b0;
      bl_hold_q <= '0;
      win_q     <= '0;
      out_pix_q <= '0;
      last_q    <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rdy_q   <= 1'b1;

      if (w_hs && w_row_odd && !w_col_odd) begin
        bl_hold_q <= pix_in;
      end

      if (w_blk_done) begin
        win_q[0][0] <= rowbuf_q[w_left_addr];
        win_q[0][1] <= rowbuf_q[col_q];
        win_q[1][0] <= bl_hold_q;
        win_q[1][1] <= pix_in;
        last_q      <= w_row_last && w_col_last;
      end

      if ((state_q == S_ISSUE) && pool_finish) begin
        out_pix_q <= pool_pixel;
      end

      fd_q <= (state_q == S_OUTPUT) && out_ready && last_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pool2x2_window_feeder.sv
// ============================================================================
// tb_pool2x2_window_feeder
// Randomized self-checking bench with an image-level reference model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pool2x2_window_feeder;

  localparam int TW = 4;
  localparam int TH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [15:0]           pix_in;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pool_start;
  logic [1:0][1:0][15:0] pool_win;
  logic                  pool_finish;
  logic [15:0]           pool_pixel;
  logic [15:0]           out_pixel;
  logic                  out_valid;
  logic                  out_ready;
  logic                  frame_done;

  pool2x2_window_feeder #(.W(TW), .H(TH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pool_start  (pool_start),
    .pool_win    (pool_win),
    .pool_finish (pool_finish),
    .pool_pixel  (pool_pixel),
    .out_pixel   (out_pixel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] w;
    logic [15:0]      avg;
    logic             last;
  } blk_t;

  blk_t        exp_q[$];
  logic [15:0] got_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pooler model: mean of the window, finishing pool_delay cycles after start.
  int pool_delay = 0;
  int pool_cnt   = 0;
  always @(posedge clk) pool_cnt <= pool_start ? pool_cnt + 1 : 0;
  assign pool_finish = pool_start && (pool_cnt >= pool_delay);
  always_comb begin
    int s;
    s = int'($signed(pool_win[0][0])) + int'($signed(pool_win[0][1]))
      + int'($signed(pool_win[1][0])) + int'($signed(pool_win[1][1]));
    pool_pixel = 16'(s >>> 2);
  end

  // Reference: rebuild the image from accepted pixels, emit one entry per block.
  logic [15:0] img [TH][TW];
  int          m_r = 0;
  int          m_c = 0;

  function automatic logic [15:0] floor_avg4(input logic [15:0] a, b, c, d);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'($signed(c)) + int'($signed(d));
    if (s >= 0) return 16'(s / 4);
    return 16'(-((-s + 3) / 4));
  endfunction

  task automatic model_accept(input logic [15:0] v);
    blk_t b;
    img[m_r][m_c] = v;
    if ((m_r % 2 == 1) && (m_c % 2 == 1)) begin
      b.w[0] = img[m_r-1][m_c-1];
      b.w[1] = img[m_r-1][m_c];
      b.w[2] = img[m_r][m_c-1];
      b.w[3] = v;
      b.avg  = floor_avg4(b.w[0], b.w[1], b.w[2], b.w[3]);
      b.last = (m_r == TH - 1) && (m_c == TW - 1);
      exp_q.push_back(b);
    end
    m_c++;
    if (m_c == TW) begin
      m_c = 0;
      m_r = (m_r == TH - 1) ? 0 : m_r + 1;
    end
  endtask

  // out_ready policy: 0 always ready, 1 random, 2 hold off 3 cycles per output.
  int or_mode = 0;
  int ovc     = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ovc = out_valid ? ovc + 1 : 0;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (ovc > 3);
      endcase
    end
  end

  logic                  ps_prev = 1'b0;
  logic                  ov_prev = 1'b0;
  logic                  or_prev = 1'b0;
  logic                  fd_pending = 1'b0;
  logic [15:0]           pix_prev = '0;
  logic [1:0][1:0][15:0] win_prev = '0;
  int                    ps_len = 0;
  int                    exp_ps_len = 1;
  int                    fd_count = 0;
  blk_t                  mb;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ps_prev = 0; ov_prev = 0; or_prev = 0; fd_pending = 0; ps_len = 0;
        continue;
      end
      chk("frame_done", frame_done, fd_pending);
      if (frame_done) fd_count++;
      fd_pending = 0;

      if (pool_start) begin
        chk("rdy_in_issue", pix_ready, 0);
        if (!ps_prev) begin
          ps_len = 1;
          if (exp_q.size() == 0) chk("issue_unexp", 1, 0);
          else for (int k = 0; k < 4; k++) chk("win", pool_win[k/2][k%2], exp_q[0].w[k]);
        end else begin
          ps_len++;
          chk("win_stable", pool_win, win_prev);
        end
      end else if (ps_prev) begin
        chk("start_len", ps_len, exp_ps_len);
      end

      if (out_valid) begin
        chk("rdy_in_out", pix_ready, 0);
        chk("start_in_out", pool_start, 0);
        chk("win_hold", pool_win, win_prev);
        if (!ov_prev) chk("ov_lat", ps_prev, 1);
        else if (!or_prev) chk("out_hold", out_pixel, pix_prev);
        if (out_ready) begin
          got_q.push_back(out_pixel);
          if (exp_q.size() == 0) chk("out_unexp", 1, 0);
          else begin
            mb = exp_q.pop_front();
            chk("out_pix", out_pixel, mb.avg);
            fd_pending = mb.last;
          end
        end
      end
      ps_prev = pool_start; ov_prev = out_valid; or_prev = out_ready;
      pix_prev = out_pixel; win_prev = pool_win;
    end
  end

  task automatic send(input logic [15:0] v, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    pix_valid = 1'b1;
    pix_in    = v;
    n = 0;
    forever begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk); #1;
        pix_valid = 1'b0;
        model_accept(v);
        break;
      end
      n++;
      if (n > 200) begin
        chk("pix_timeout", 0, 1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset(input int cyc);
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    exp_q.delete();
    m_r = 0;
    m_c = 0;
    repeat (cyc) begin
      @(negedge clk);
      chk("rst_ready", pix_ready, 0);
      chk("rst_start", pool_start, 0);
      chk("rst_win", pool_win, 0);
      chk("rst_opix", out_pixel, 0);
      chk("rst_oval", out_valid, 0);
      chk("rst_fd", frame_done, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rdy_after_rst", pix_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", n < 200, 1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input bit ramp, input bit gaps);
    for (int i = 0; i < TW * TH; i++) send(ramp ? 16'(i) : 16'($urandom), gaps);
  endtask

  task automatic check_ramp(input int fd0);
    int ramp_exp [4];
    ramp_exp = '{2, 4, 10, 12};
    chk("ramp_count", got_q.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got_q.size()) chk("ramp_val", got_q[k], 16'(ramp_exp[k]));
    chk("ramp_fd", fd_count - fd0, 1);
  endtask

  int          fd0;
  logic [15:0] blk_vals [16];

  initial begin
    rst_n = 1'b0; pix_valid = 1'b0; pix_in = '0;
    @(posedge clk); #1;
    do_reset(3);

    // First block carries 4,8 / 12,16 -> 10.
    blk_vals = '{16'd4, 16'd8, 16'd1, 16'd2, 16'd12, 16'd16, 16'd3, 16'd4,
                 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};
    got_q.delete(); fd0 = fd_count;
    for (int i = 0; i < 16; i++) send(blk_vals[i], 1'b0);
    drain();
    chk("blk_count", got_q.size(), 4);
    if (got_q.size() > 0) chk("blk_first", got_q[0], 16'd10);
    chk("blk_fd", fd_count - fd0, 1);

    got_q.delete(); fd0 = fd_count;
    send_frame(1'b1, 1'b0);
    drain();
    check_ramp(fd0);

    pool_delay = 5; exp_ps_len = 6; or_mode = 2;
    got_q.delete(); fd0 = fd_count;
    send_frame(1'b0, 1'b0);
    drain();
    chk("bp_count", got_q.size(), 4);
    chk("bp_fd", fd_count - fd0, 1);
    pool_delay = 0; exp_ps_len = 1; or_mode = 0;

    for (int i = 0; i < 9; i++) send(16'(i), 1'b0);
    do_reset(2);
    got_q.delete(); fd0 = fd_count;
    send_frame(1'b1, 1'b0);
    drain();
    check_ramp(fd0);

    or_mode = 1;
    got_q.delete(); fd0 = fd_count;
    send_frame(1'b1, 1'b1);
    drain();
    check_ramp(fd0);

    repeat (4) begin
      pool_delay = $urandom_range(0, 3);
      exp_ps_len = pool_delay + 1;
      fd0 = fd_count;
      send_frame(1'b0, 1'b1);
      drain();
      chk("rand_fd", fd_count - fd0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
